// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the MEM-stage data SRAM responder: FSM encoding,
// data width and the byte-address to word-index helper.
package data_sram_responder_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Word index of a byte address; the low two bits and everything above the
    // RAM depth are dropped, so out-of-range addresses wrap.
    function automatic logic [31:0] word_idx(input logic [31:0] addr, input int addr_w);
        logic [31:0] mask;
        mask = (32'd1 << addr_w) - 32'd1;
        return (addr >> 2) & mask;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// MEM stage <-> data SRAM responder request/response bundle.
// A request is presented on req_en and held until retired; the responder
// returns one single-cycle pulse, and mem_done marks the response as consumed.
interface data_sram_responder_if;
    import data_sram_responder_pkg::*;

    logic              req_en;
    logic [3:0]        req_we;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              mem_done;
    logic              data_ready;
    logic              data_valid;
    logic [DATA_W-1:0] rdata;
    state_t            dbg_state;

    modport master (
        output req_en, req_we, req_addr, req_wdata, mem_done,
        input  data_ready, data_valid, rdata, dbg_state
    );

    modport slave (
        input  req_en, req_we, req_addr, req_wdata, mem_done,
        output data_ready, data_valid, rdata, dbg_state
    );
endinterface

// File: rtl/data_sram_responder_data_ram_be.sv
// Synchronous single-port word RAM with per-byte write enables and a
// registered, read-before-write output.
module data_ram_be #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder: accepts a MEM-stage request, performs it on the data
// RAM after LATENCY cycles and returns a one-cycle store/load completion pulse.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 10
) (
    input logic                 clk,
    input logic                 rst,
    data_sram_responder_if.slave bus
);

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [3:0]        we_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              accept;
    logic              last_busy;
    logic [ADDR_W-1:0] req_idx;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rdata;

    assign req_idx = bus.req_addr[ADDR_W+1:2];

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        accept    = 1'b0;
        last_busy = 1'b0;
        case (state)
            S_IDLE: begin
                accept = bus.req_en;
                if (bus.req_en) state_n = S_BUSY;
            end
            S_BUSY: begin
                last_busy = (cnt == 4'd0);
                if (cnt == 4'd0) state_n = S_HOLD;
                else             cnt_n   = cnt - 4'd1;
            end
            S_HOLD: begin
                // While mem_done is high, req_en still belongs to the retired request.
                if (!bus.mem_done) begin
                    accept  = bus.req_en;
                    state_n = bus.req_en ? S_BUSY : S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (accept) cnt_n = 4'(LATENCY - 1);
    end

    // The RAM read register must hold RAM[idx] by the final BUSY edge, so the
    // read is issued one edge earlier; with LATENCY=1 that is the accept edge.
    assign ram_addr = (state == S_BUSY) ? idx_q : req_idx;
    assign ram_we   = (last_busy && !rst) ? we_q : 4'b0000;

    data_ram_be #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= 4'd0;
            we_q           <= 4'b0000;
            idx_q          <= '0;
            wdata_q        <= 32'd0;
            bus.data_ready <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.rdata      <= 32'd0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            bus.data_ready <= last_busy && (we_q != 4'b0000);
            bus.data_valid <= last_busy && (we_q == 4'b0000);
            if (accept) begin
                we_q    <= bus.req_we;
                idx_q   <= req_idx;
                wdata_q <= bus.req_wdata;
            end
            if (last_busy && (we_q == 4'b0000)) bus.rdata <= ram_rdata;
        end
    end

    assign bus.dbg_state = state;

endmodule
